// File: rtl/udp_cmd_decoder.sv
// UDP command endpoint: validates fixed 4-byte command datagrams and drives capture controls.
// Define UDP_CMD_COUNTERS_EN to keep the saturating cmd/err counters; otherwise both read 8'h00.
//
// state   | meaning
// IDLE    | waiting for a header; stray payload beats are discarded
// PAYLOAD | latching command bytes 0..3 by index
// DROP    | discarding the rest of a foreign or malformed datagram
// EXEC    | one-cycle validate and apply of the latched command
module udp_cmd_decoder #(
  parameter logic [15:0] CMD_PORT   = 16'h1001,
  parameter logic [7:0]  MAGIC      = 8'hA5,
  parameter logic [15:0] PKTLEN_RST = 16'd1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_udp_hdr_valid,
  output logic        s_udp_hdr_ready,
  input  logic [15:0] s_udp_dest_port,
  input  logic [15:0] s_udp_length,
  input  logic [7:0]  s_udp_payload_axis_tdata,
  input  logic        s_udp_payload_axis_tvalid,
  output logic        s_udp_payload_axis_tready,
  input  logic        s_udp_payload_axis_tlast,
  input  logic        s_udp_payload_axis_tuser,
  output logic        start_pulse,
  output logic        adc_en,
  output logic [5:0]  chan_mask,
  output logic [15:0] pkt_len,
  output logic [7:0]  cmd_count,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_DROP, S_EXEC} state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  magic_q, magic_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  arg_hi_q, arg_hi_d;
  logic [7:0]  arg_lo_q, arg_lo_d;
  logic        tuser_q, tuser_d;
  logic        err_pend_q, err_pend_d;
  logic        hdr_ready_q, hdr_ready_d;
  logic        tready_q, tready_d;
  logic        start_pulse_q, start_pulse_d;
  logic        adc_en_q, adc_en_d;
  logic [5:0]  chan_mask_q, chan_mask_d;
  logic [15:0] pkt_len_q, pkt_len_d;
  logic        cmd_inc, err_inc;
  logic [15:0] arg;
  logic        hdr_fire, beat;

  assign arg      = {arg_hi_q, arg_lo_q};
  assign hdr_fire = s_udp_hdr_valid && hdr_ready_q;
  assign beat     = s_udp_payload_axis_tvalid && tready_q;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    magic_d       = magic_q;
    opcode_d      = opcode_q;
    arg_hi_d      = arg_hi_q;
    arg_lo_d      = arg_lo_q;
    tuser_d       = tuser_q;
    err_pend_d    = err_pend_q;
    start_pulse_d = 1'b0;
    adc_en_d      = adc_en_q;
    chan_mask_d   = chan_mask_q;
    pkt_len_d     = pkt_len_q;
    cmd_inc       = 1'b0;
    err_inc       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hdr_fire) begin
          idx_d = 2'd0;
          // Foreign port wins over a bad length so foreign traffic never counts as an error.
          if (s_udp_dest_port != CMD_PORT) begin
            state_d    = S_DROP;
            err_pend_d = 1'b0;
          end else if (s_udp_length != 16'd12) begin
            state_d    = S_DROP;
            err_pend_d = 1'b1;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (beat) begin
          case (idx_q)
            2'd0:    magic_d  = s_udp_payload_axis_tdata;
            2'd1:    opcode_d = s_udp_payload_axis_tdata;
            2'd2:    arg_hi_d = s_udp_payload_axis_tdata;
            default: arg_lo_d = s_udp_payload_axis_tdata;
          endcase
          if (s_udp_payload_axis_tlast && idx_q != 2'd3) begin
            state_d = S_IDLE;
            err_inc = 1'b1;
          end else if (idx_q == 2'd3 && !s_udp_payload_axis_tlast) begin
            state_d    = S_DROP;
            err_pend_d = 1'b1;
          end else if (idx_q == 2'd3) begin
            state_d = S_EXEC;
            tuser_d = s_udp_payload_axis_tuser;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_DROP: begin
        if (beat && s_udp_payload_axis_tlast) begin
          state_d = S_IDLE;
          err_inc = err_pend_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (tuser_q || magic_q != MAGIC) begin
          err_inc = 1'b1;
        end else begin
          case (opcode_q)
            8'h01: begin
              start_pulse_d = 1'b1;
              cmd_inc       = 1'b1;
            end
            8'h02: begin
              adc_en_d = arg[0];
              cmd_inc  = 1'b1;
            end
            8'h03: begin
              chan_mask_d = arg[5:0];
              cmd_inc     = 1'b1;
            end
            8'h04: begin
              if (arg >= 16'd8 && arg <= 16'd1472 && !arg[0]) begin
                pkt_len_d = arg;
                cmd_inc   = 1'b1;
              end else begin
                err_inc = 1'b1;
              end
            end
            default: err_inc = 1'b1;
          endcase
        end
      end
    endcase

    hdr_ready_d = (state_d == S_IDLE);
    tready_d    = (state_d != S_EXEC);
  end

`ifdef UDP_CMD_COUNTERS_EN
  logic [7:0] cmd_count_q, cmd_count_d;
  logic [7:0] err_count_q, err_count_d;

  always_comb begin
    cmd_count_d = cmd_count_q;
    err_count_d = err_count_q;
    if (cmd_inc && cmd_count_q != 8'hFF) cmd_count_d = cmd_count_q + 8'd1;
    if (err_inc && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
  end

  assign cmd_count = cmd_count_q;
  assign err_count = err_count_q;
`else
  logic unused_inc;
  assign unused_inc = cmd_inc ^ err_inc;
  assign cmd_count  = 8'h00;
  assign err_count  = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= 2'd0;
      magic_q       <= 8'h00;
      opcode_q      <= 8'h00;
      arg_hi_q      <= 8'h00;
      arg_lo_q      <= 8'h00;
      tuser_q       <= 1'b0;
      err_pend_q    <= 1'b0;
      hdr_ready_q   <= 1'b1;
      tready_q      <= 1'b1;
      start_pulse_q <= 1'b0;
      adc_en_q      <= 1'b0;
      chan_mask_q   <= 6'h3F;
      pkt_len_q     <= PKTLEN_RST;
`ifdef UDP_CMD_COUNTERS_EN
      cmd_count_q   <= 8'h00;
      err_count_q   <= 8'h00;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      magic_q       <= magic_d;
      opcode_q      <= opcode_d;
      arg_hi_q      <= arg_hi_d;
      arg_lo_q      <= arg_lo_d;
      tuser_q       <= tuser_d;
      err_pend_q    <= err_pend_d;
      hdr_ready_q   <= hdr_ready_d;
      tready_q      <= tready_d;
      start_pulse_q <= start_pulse_d;
      adc_en_q      <= adc_en_d;
      chan_mask_q   <= chan_mask_d;
      pkt_len_q     <= pkt_len_d;
`ifdef UDP_CMD_COUNTERS_EN
      cmd_count_q   <= cmd_count_d;
      err_count_q   <= err_count_d;
`endif
    end
  end

  assign s_udp_hdr_ready           = hdr_ready_q;
  assign s_udp_payload_axis_tready = tready_q;
  assign start_pulse               = start_pulse_q;
  assign adc_en                    = adc_en_q;
  assign chan_mask                 = chan_mask_q;
  assign pkt_len                   = pkt_len_q;

endmodule

// File: tb/tb_udp_cmd_decoder.sv
// Directed table-driven bench for udp_cmd_decoder, plus reset-mid-datagram and counter saturation.
// Counter expectations follow UDP_CMD_COUNTERS_EN exactly as the design build does.
module tb_udp_cmd_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_udp_hdr_valid;
  logic        s_udp_hdr_ready;
  logic [15:0] s_udp_dest_port;
  logic [15:0] s_udp_length;
  logic [7:0]  s_udp_payload_axis_tdata;
  logic        s_udp_payload_axis_tvalid;
  logic        s_udp_payload_axis_tready;
  logic        s_udp_payload_axis_tlast;
  logic        s_udp_payload_axis_tuser;
  logic        start_pulse;
  logic        adc_en;
  logic [5:0]  chan_mask;
  logic [15:0] pkt_len;
  logic [7:0]  cmd_count;
  logic [7:0]  err_count;

  udp_cmd_decoder dut (
    .clk                       (clk),
    .reset                     (reset),
    .s_udp_hdr_valid           (s_udp_hdr_valid),
    .s_udp_hdr_ready           (s_udp_hdr_ready),
    .s_udp_dest_port           (s_udp_dest_port),
    .s_udp_length              (s_udp_length),
    .s_udp_payload_axis_tdata  (s_udp_payload_axis_tdata),
    .s_udp_payload_axis_tvalid (s_udp_payload_axis_tvalid),
    .s_udp_payload_axis_tready (s_udp_payload_axis_tready),
    .s_udp_payload_axis_tlast  (s_udp_payload_axis_tlast),
    .s_udp_payload_axis_tuser  (s_udp_payload_axis_tuser),
    .start_pulse               (start_pulse),
    .adc_en                    (adc_en),
    .chan_mask                 (chan_mask),
    .pkt_len                   (pkt_len),
    .cmd_count                 (cmd_count),
    .err_count                 (err_count)
  );

  always #4 clk = ~clk;

  typedef struct {
    logic [15:0] port;
    logic [15:0] len;
    int          nb;
    logic [63:0] data;   // byte0 in [63:56]
    logic        tuser;
    int          pulses;
    logic        adc;
    logic [5:0]  mask;
    logic [15:0] pkt;
    int          cmd;
    int          err;
  } vec_t;

  vec_t vt[21];
  int   vectors = 0;
  int   miscompares = 0;
  int   pulse_total = 0;
  int   pulse_run = 0;
  int   pulse_max_run = 0;

  always @(negedge clk) begin
    if (start_pulse === 1'b1) begin
      pulse_total = pulse_total + 1;
      pulse_run   = pulse_run + 1;
      if (pulse_run > pulse_max_run) pulse_max_run = pulse_run;
    end else begin
      pulse_run = 0;
    end
  end

  function automatic int ec(input int v);
`ifdef UDP_CMD_COUNTERS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  function automatic vec_t mk(input logic [15:0] port, input logic [15:0] len, input int nb,
                              input logic [63:0] data, input logic tuser, input int pulses,
                              input logic adc, input logic [5:0] mask, input logic [15:0] pkt,
                              input int cmd, input int err);
    vec_t v;
    v.port = port; v.len = len; v.nb = nb; v.data = data; v.tuser = tuser;
    v.pulses = pulses; v.adc = adc; v.mask = mask; v.pkt = pkt;
    v.cmd = ec(cmd); v.err = ec(err);
    return v;
  endfunction

  task automatic chk(input string nm, input int vi, input longint act, input longint exp);
    vectors = vectors + 1;
    if (act != exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s (vector %0d): got 0x%0h, expected 0x%0h", nm, vi, act, exp);
    end
  endtask

  task automatic send(input int vi, input logic [15:0] port, input logic [15:0] len,
                      input int nb, input logic [63:0] data, input logic tu,
                      output int stalls, output logic [2:0] lat);
    int w;
    stalls = 0;
    @(negedge clk);
    s_udp_hdr_valid = 1'b1;
    s_udp_dest_port = port;
    s_udp_length    = len;
    w = 0;
    while (s_udp_hdr_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("hdr_ready_wait_expired", vi, (w >= 50), 0);
    @(posedge clk);
    @(negedge clk);
    s_udp_hdr_valid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      s_udp_payload_axis_tvalid = 1'b1;
      s_udp_payload_axis_tdata  = data[63 - 8*i -: 8];
      s_udp_payload_axis_tlast  = (i == nb - 1);
      s_udp_payload_axis_tuser  = tu && (i == nb - 1);
      w = 0;
      while (s_udp_payload_axis_tready !== 1'b1 && w < 50) begin
        stalls++;
        @(negedge clk);
        w++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    s_udp_payload_axis_tvalid = 1'b0;
    s_udp_payload_axis_tlast  = 1'b0;
    s_udp_payload_axis_tuser  = 1'b0;
    lat[0] = start_pulse;
    @(negedge clk);
    lat[1] = start_pulse;
    @(negedge clk);
    lat[2] = start_pulse;
  endtask

  initial begin
    int          stalls;
    int          p0;
    logic [2:0]  lat;

    vt[0]  = mk(16'h1001, 16'd12, 4, 64'hA501_0000_0000_0000, 1'b0, 1, 1'b0, 6'h3F, 16'd1024, 1, 0);
    vt[1]  = mk(16'h1001, 16'd12, 4, 64'hA503_0015_0000_0000, 1'b0, 0, 1'b0, 6'h15, 16'd1024, 2, 0);
    vt[2]  = mk(16'h1001, 16'd12, 4, 64'hA502_0001_0000_0000, 1'b0, 0, 1'b1, 6'h15, 16'd1024, 3, 0);
    vt[3]  = mk(16'h1001, 16'd12, 4, 64'hA504_0408_0000_0000, 1'b0, 0, 1'b1, 6'h15, 16'd1032, 4, 0);
    vt[4]  = mk(16'h1001, 16'd12, 4, 64'hA504_0601_0000_0000, 1'b0, 0, 1'b1, 6'h15, 16'd1032, 4, 1);
    vt[5]  = mk(16'h1001, 16'd12, 4, 64'h5A01_0000_0000_0000, 1'b0, 0, 1'b1, 6'h15, 16'd1032, 4, 2);
    vt[6]  = mk(16'h1001, 16'd12, 4, 64'hA57F_0000_0000_0000, 1'b0, 0, 1'b1, 6'h15, 16'd1032, 4, 3);
    vt[7]  = mk(16'h1001, 16'd12, 3, 64'hA501_0000_0000_0000, 1'b0, 0, 1'b1, 6'h15, 16'd1032, 4, 4);
    vt[8]  = mk(16'h1001, 16'd12, 6, 64'hA501_0000_0000_0000, 1'b0, 0, 1'b1, 6'h15, 16'd1032, 4, 5);
    vt[9]  = mk(16'h1001, 16'd12, 4, 64'hA501_0000_0000_0000, 1'b1, 0, 1'b1, 6'h15, 16'd1032, 4, 6);
    vt[10] = mk(16'h1000, 16'd12, 4, 64'hA501_0000_0000_0000, 1'b0, 0, 1'b1, 6'h15, 16'd1032, 4, 6);
    vt[11] = mk(16'h1001, 16'd13, 4, 64'hA501_0000_0000_0000, 1'b0, 0, 1'b1, 6'h15, 16'd1032, 4, 7);
    vt[12] = mk(16'h1001, 16'd12, 4, 64'hA504_0008_0000_0000, 1'b0, 0, 1'b1, 6'h15, 16'd8,    5, 7);
    vt[13] = mk(16'h1001, 16'd12, 4, 64'hA504_05C0_0000_0000, 1'b0, 0, 1'b1, 6'h15, 16'd1472, 6, 7);
    vt[14] = mk(16'h1001, 16'd12, 4, 64'hA504_0007_0000_0000, 1'b0, 0, 1'b1, 6'h15, 16'd1472, 6, 8);
    vt[15] = mk(16'h1001, 16'd12, 4, 64'hA504_05C2_0000_0000, 1'b0, 0, 1'b1, 6'h15, 16'd1472, 6, 9);
    vt[16] = mk(16'h1001, 16'd12, 4, 64'hA504_0006_0000_0000, 1'b0, 0, 1'b1, 6'h15, 16'd1472, 6, 10);
    vt[17] = mk(16'h1000, 16'd7,  2, 64'hA501_0000_0000_0000, 1'b0, 0, 1'b1, 6'h15, 16'd1472, 6, 10);
    vt[18] = mk(16'h1001, 16'd12, 4, 64'hA502_0000_0000_0000, 1'b0, 0, 1'b0, 6'h15, 16'd1472, 7, 10);
    vt[19] = mk(16'h1001, 16'd12, 4, 64'hA503_FFEA_0000_0000, 1'b0, 0, 1'b0, 6'h2A, 16'd1472, 8, 10);
    vt[20] = mk(16'h1001, 16'd12, 4, 64'hA501_0000_0000_0000, 1'b0, 1, 1'b0, 6'h2A, 16'd1472, 9, 10);

    reset = 1'b1;
    s_udp_hdr_valid = 1'b0;
    s_udp_dest_port = 16'h0;
    s_udp_length = 16'h0;
    s_udp_payload_axis_tdata = 8'h00;
    s_udp_payload_axis_tvalid = 1'b0;
    s_udp_payload_axis_tlast = 1'b0;
    s_udp_payload_axis_tuser = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_hdr_ready", -1, s_udp_hdr_ready, 1);
    chk("rst_tready", -1, s_udp_payload_axis_tready, 1);
    chk("rst_start_pulse", -1, start_pulse, 0);
    chk("rst_adc_en", -1, adc_en, 0);
    chk("rst_chan_mask", -1, chan_mask, 6'h3F);
    chk("rst_pkt_len", -1, pkt_len, 16'd1024);
    chk("rst_cmd_count", -1, cmd_count, 0);
    chk("rst_err_count", -1, err_count, 0);

    for (int vi = 0; vi < 21; vi++) begin
      p0 = pulse_total;
      send(vi, vt[vi].port, vt[vi].len, vt[vi].nb, vt[vi].data, vt[vi].tuser, stalls, lat);
      repeat (2) @(negedge clk);
      chk("pulse_timing", vi, lat, (vt[vi].pulses != 0) ? 3'b010 : 3'b000);
      chk("pulse_count", vi, pulse_total - p0, vt[vi].pulses);
      chk("tready_stalls", vi, stalls, 0);
      chk("adc_en", vi, adc_en, vt[vi].adc);
      chk("chan_mask", vi, chan_mask, vt[vi].mask);
      chk("pkt_len", vi, pkt_len, vt[vi].pkt);
      chk("cmd_count", vi, cmd_count, vt[vi].cmd);
      chk("err_count", vi, err_count, vt[vi].err);
    end
    chk("pulse_width", 21, pulse_max_run, 1);

    // Reset lands after byte1 of a MASK command; the trailing bytes arrive as orphans.
    p0 = pulse_total;
    @(negedge clk);
    s_udp_hdr_valid = 1'b1;
    s_udp_dest_port = 16'h1001;
    s_udp_length    = 16'd12;
    @(posedge clk);
    @(negedge clk);
    s_udp_hdr_valid = 1'b0;
    s_udp_payload_axis_tvalid = 1'b1;
    s_udp_payload_axis_tdata  = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    s_udp_payload_axis_tdata  = 8'h03;
    @(posedge clk);
    @(negedge clk);
    s_udp_payload_axis_tvalid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    s_udp_payload_axis_tvalid = 1'b1;
    s_udp_payload_axis_tdata  = 8'h00;
    @(posedge clk);
    @(negedge clk);
    s_udp_payload_axis_tdata  = 8'h15;
    s_udp_payload_axis_tlast  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_udp_payload_axis_tvalid = 1'b0;
    s_udp_payload_axis_tlast  = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_chan_mask", 100, chan_mask, 6'h3F);
    chk("midrst_adc_en", 100, adc_en, 0);
    chk("midrst_pkt_len", 100, pkt_len, 16'd1024);
    chk("midrst_cmd_count", 100, cmd_count, 0);
    chk("midrst_err_count", 100, err_count, 0);
    chk("midrst_hdr_ready", 100, s_udp_hdr_ready, 1);
    chk("midrst_pulses", 100, pulse_total - p0, 0);

    send(101, 16'h1001, 16'd12, 4, 64'hA501_0000_0000_0000, 1'b0, stalls, lat);
    chk("post_rst_start_timing", 101, lat, 3'b010);
    chk("post_rst_cmd_count", 101, cmd_count, ec(1));
    chk("post_rst_err_count", 101, err_count, 0);

    // Back-to-back bad-magic datagrams drive err_count into saturation.
    for (int k = 0; k < 260; k++) begin
      send(200, 16'h1001, 16'd12, 4, 64'h5A01_0000_0000_0000, 1'b0, stalls, lat);
      if (k == 254) chk("err_count_at_255", 200, err_count, ec(255));
    end
    repeat (2) @(negedge clk);
    chk("err_count_saturated", 201, err_count, ec(255));
    chk("cmd_count_after_sat", 201, cmd_count, ec(1));
    chk("mask_after_sat", 201, chan_mask, 6'h3F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
